// File: rtl/fft_pkg.sv
// Shared constants and state encoding for the FFT magnitude stage.
package fft_pkg;

    localparam int unsigned DW    = 12;  // signed input component width
    localparam int unsigned SCALE = 10;  // twiddle scale removed before squaring
    localparam int unsigned MW    = 9;   // magnitude width
    localparam int unsigned RW    = 18;  // radicand width, holds 2*204^2
    localparam int unsigned NBINS = 8;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StCalc = 2'd1;
    localparam logic [1:0] StSqrt = 2'd2;
    localparam logic [1:0] StOut  = 2'd3;

endpackage

// File: rtl/fft8_mag_seq_if.sv
// Frame input and magnitude output handshakes of the FFT magnitude stage.
interface fft8_mag_seq_if;
    import fft_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] Yr0, Yr1, Yr2, Yr3, Yr4, Yr5, Yr6, Yr7;
    logic signed [DW-1:0] Yi0, Yi1, Yi2, Yi3, Yi4, Yi5, Yi6, Yi7;
    logic                 mag_valid;
    logic                 mag_ready;
    logic [MW-1:0]        mag_out;
    logic [2:0]           mag_idx;
    logic                 mag_last;

    // Upstream FFT / downstream writer side
    modport master (
        output in_valid, Yr0, Yr1, Yr2, Yr3, Yr4, Yr5, Yr6, Yr7,
        output Yi0, Yi1, Yi2, Yi3, Yi4, Yi5, Yi6, Yi7, mag_ready,
        input  in_ready, mag_valid, mag_out, mag_idx, mag_last
    );

    // Magnitude block side
    modport slave (
        input  in_valid, Yr0, Yr1, Yr2, Yr3, Yr4, Yr5, Yr6, Yr7,
        input  Yi0, Yi1, Yi2, Yi3, Yi4, Yi5, Yi6, Yi7, mag_ready,
        output in_ready, mag_valid, mag_out, mag_idx, mag_last
    );

endinterface

// File: rtl/fft8_mag_seq_isqrt.sv
// Restoring digit-by-digit integer square root, one root bit per clock.
module isqrt_seq
    import fft_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [RW-1:0] radicand,
    output logic          busy,
    output logic          done,   // high during the final iteration cycle
    output logic [MW-1:0] root
);

    logic [RW-1:0] rad_q;
    logic [RW-1:0] rem_q;
    logic [MW-1:0] root_q;
    logic [3:0]    cnt_q;
    logic          busy_q;
    logic [RW+1:0] rem_t;
    logic [RW+1:0] trial;
    logic          take;

    // Trial subtraction of (4*root + 1) against the remainder with the next bit pair appended
    always_comb begin
        rem_t = {rem_q, rad_q[RW-1:RW-2]};
        trial = {{(RW - MW){1'b0}}, root_q, 2'b01};
        take  = (rem_t >= trial);
    end

    // Iteration registers: load on start, then shift two radicand bits per cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rad_q  <= '0;
            rem_q  <= '0;
            root_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start) begin
            rad_q  <= radicand;
            rem_q  <= '0;
            root_q <= '0;
            cnt_q  <= 4'd8;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            rad_q  <= rad_q << 2;
            rem_q  <= take ? RW'(rem_t - trial) : RW'(rem_t);
            root_q <= {root_q[MW-2:0], take};
            if (cnt_q == 4'd0) begin
                busy_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - 4'd1;
            end
        end
    end

    assign busy = busy_q;
    // Flagged one cycle early so the caller's state advances on the same edge the root completes
    assign done = busy_q && (cnt_q == 4'd0);
    assign root = root_q;

endmodule

// File: rtl/fft8_mag_seq.sv
// Per-bin magnitude of an 8-bin FFT frame, streamed out in bin order.
module fft8_mag_seq
    import fft_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    fft8_mag_seq_if.slave bus
);

    localparam logic signed [DW-1:0] ScaleS = DW'(SCALE);

    logic [1:0]           state_q;
    logic [2:0]           idx_q;
    logic signed [DW-1:0] yr_q [NBINS];
    logic signed [DW-1:0] yi_q [NBINS];

    logic                 in_ready;
    logic                 sq_start;
    logic                 sq_busy;
    logic                 sq_done;
    logic [MW-1:0]        sq_root;
    logic signed [DW-1:0] r_div;
    logic signed [DW-1:0] i_div;
    logic signed [23:0]   r_w;
    logic signed [23:0]   i_w;
    logic [RW-1:0]        rad_calc;

    // Descale the selected bin (truncating toward zero) and form re^2 + im^2
    always_comb begin
        r_div    = yr_q[idx_q] / ScaleS;
        i_div    = yi_q[idx_q] / ScaleS;
        r_w      = r_div;
        i_w      = i_div;
        rad_calc = RW'($unsigned(r_w * r_w + i_w * i_w));
    end

    assign sq_start = (state_q == StCalc);

    isqrt_seq u_isqrt (
        .clk      (clk),
        .rst      (rst),
        .start    (sq_start),
        .radicand (rad_calc),
        .busy     (sq_busy),
        .done     (sq_done),
        .root     (sq_root)
    );

    // Frame capture, bin sequencing and output handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            for (int k = 0; k < NBINS; k++) begin
                yr_q[k] <= '0;
                yi_q[k] <= '0;
            end
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.in_valid && in_ready) begin
                        yr_q[0] <= bus.Yr0;  yi_q[0] <= bus.Yi0;
                        yr_q[1] <= bus.Yr1;  yi_q[1] <= bus.Yi1;
                        yr_q[2] <= bus.Yr2;  yi_q[2] <= bus.Yi2;
                        yr_q[3] <= bus.Yr3;  yi_q[3] <= bus.Yi3;
                        yr_q[4] <= bus.Yr4;  yi_q[4] <= bus.Yi4;
                        yr_q[5] <= bus.Yr5;  yi_q[5] <= bus.Yi5;
                        yr_q[6] <= bus.Yr6;  yi_q[6] <= bus.Yi6;
                        yr_q[7] <= bus.Yr7;  yi_q[7] <= bus.Yi7;
                        idx_q   <= '0;
                        state_q <= StCalc;
                    end
                end
                StCalc: state_q <= StSqrt;
                StSqrt: begin
                    if (sq_done) begin
                        state_q <= StOut;
                    end
                end
                default: begin
                    if (bus.mag_ready) begin
                        if (idx_q == 3'd7) begin
                            state_q <= StIdle;
                        end else begin
                            idx_q   <= idx_q + 3'd1;
                            state_q <= StCalc;
                        end
                    end
                end
            endcase
        end
    end

    assign in_ready      = (state_q == StIdle) && !sq_busy;
    assign bus.in_ready  = in_ready;
    assign bus.mag_valid = (state_q == StOut);
    assign bus.mag_out   = (state_q == StOut) ? sq_root : '0;
    assign bus.mag_idx   = idx_q;
    assign bus.mag_last  = (state_q == StOut) && (idx_q == 3'd7);

endmodule

// File: tb/tb_fft8_mag_seq.sv
// Self-checking bench for fft8_mag_seq against a behavioural magnitude model.
module tb_fft8_mag_seq;
    import fft_pkg::*;

    typedef int arr8_t[8];
    typedef struct {
        int idx;
        int mag;
        int lit;   // hand-computed value, -1 when none
        int due;   // cycle at which bin 0 must first be seen
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tvalid = 1'b0;
    logic tready = 1'b1;
    logic signed [DW-1:0] tyr [NBINS];
    logic signed [DW-1:0] tyi [NBINS];

    fft8_mag_seq_if bus ();

    fft8_mag_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.in_valid  = tvalid;
    assign bus.mag_ready = tready;
    assign bus.Yr0 = tyr[0];  assign bus.Yi0 = tyi[0];
    assign bus.Yr1 = tyr[1];  assign bus.Yi1 = tyi[1];
    assign bus.Yr2 = tyr[2];  assign bus.Yi2 = tyi[2];
    assign bus.Yr3 = tyr[3];  assign bus.Yi3 = tyi[3];
    assign bus.Yr4 = tyr[4];  assign bus.Yi4 = tyi[4];
    assign bus.Yr5 = tyr[5];  assign bus.Yi5 = tyi[5];
    assign bus.Yr6 = tyr[6];  assign bus.Yi6 = tyi[6];
    assign bus.Yr7 = tyr[7];  assign bus.Yi7 = tyi[7];

    always #5 clk = ~clk;

    exp_t  q[$];
    exp_t  cur;
    int    n_cmp = 0;
    int    n_fail = 0;
    int    cycle = 0;
    int    last_hs = 0;
    int    bin7_hs = -100;
    bit    seen = 1'b0;
    bit    chain_check = 1'b0;
    bit    lit_on = 1'b0;
    arr8_t lit;
    int    ready_mode = 0;   // 0 high, 1 low, 2 random

    function automatic int model_mag(int yr, int yi);
        int r   = yr / int'(SCALE);
        int i   = yi / int'(SCALE);
        int rad = r * r + i * i;
        int m   = 0;
        while ((m + 1) * (m + 1) <= rad) m++;
        return m;
    endfunction

    task automatic check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    always @(posedge clk) cycle <= cycle + 1;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       tready = 1'b1;
            1:       tready = 1'b0;
            default: tready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Record accepted frames into the model queue and check every valid output cycle
    always @(negedge clk) begin
        if (!rst) begin
            if (tvalid && bus.in_ready) begin
                if (chain_check) begin
                    check("chain_accept_gap", cycle + 1 - bin7_hs, 1);
                    chain_check = 1'b0;
                end
                for (int k = 0; k < NBINS; k++) begin
                    q.push_back('{idx: k,
                                  mag: model_mag(int'(tyr[k]), int'(tyi[k])),
                                  lit: lit_on ? lit[k] : -1,
                                  due: cycle + 11});
                end
            end
            if (bus.mag_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    cur = q[0];
                    check("mag_out", int'(bus.mag_out), cur.mag);
                    check("mag_idx", int'(bus.mag_idx), cur.idx);
                    check("mag_last", int'(bus.mag_last), int'(cur.idx == 7));
                    check("in_ready_busy", int'(bus.in_ready), 0);
                    if (cur.lit >= 0) check("mag_literal", int'(bus.mag_out), cur.lit);
                    if (!seen) begin
                        seen = 1'b1;
                        check("valid_latency", cycle, (cur.idx == 0) ? cur.due : last_hs + 10);
                    end
                    if (tready) begin
                        void'(q.pop_front());
                        seen    = 1'b0;
                        last_hs = cycle + 1;
                        if (cur.idx == 7) bin7_hs = cycle + 1;
                    end
                end
            end
        end
    end

    task automatic set_frame(input arr8_t r, input arr8_t i, input arr8_t l, input bit use_lit);
        for (int k = 0; k < NBINS; k++) begin
            tyr[k] = DW'(r[k]);
            tyi[k] = DW'(i[k]);
        end
        lit    = l;
        lit_on = use_lit;
    endtask

    task automatic set_random_frame();
        for (int k = 0; k < NBINS; k++) begin
            tyr[k] = DW'($urandom_range(0, 4095));
            tyi[k] = DW'($urandom_range(0, 4095));
        end
        lit_on = 1'b0;
    endtask

    // Offer the frame currently on tyr/tyi until accepted
    task automatic send_frame();
        int n = 0;
        tvalid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("accept_in_time", int'(bus.in_ready), 1);
        @(posedge clk);
        #1;
        tvalid = 1'b0;
        lit_on = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (!(q.size() == 0 && bus.in_ready) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("frame_drained", int'(q.size() == 0 && bus.in_ready), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_bin(input int idx);
        int n = 0;
        @(negedge clk);
        while (!(bus.mag_valid && int'(bus.mag_idx) == idx) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("bin_reached", int'(bus.mag_valid && int'(bus.mag_idx) == idx), 1);
    endtask

    arr8_t zr, zi, none;
    arr8_t t1r, t1i, t1l;
    arr8_t t2r, t2l;
    arr8_t t3r, t3i, t3l;

    initial begin
        zr   = '{0, 0, 0, 0, 0, 0, 0, 0};
        zi   = zr;
        none = zr;
        t1r  = '{30, 0, 0, 0, 0, 0, 0, 0};
        t1i  = '{40, 0, 0, 0, 0, 0, 0, 0};
        t1l  = '{5, 0, 0, 0, 0, 0, 0, 0};
        t2r  = '{-2048, -2048, -2048, -2048, -2048, -2048, -2048, -2048};
        t2l  = '{288, 288, 288, 288, 288, 288, 288, 288};
        t3r  = '{100, 0, -55, 19, 1234, -9, 2047, 0};
        t3i  = '{0, -70, 55, 0, -567, 9, 2047, 0};
        t3l  = '{10, 7, 7, 1, 135, 0, 288, 0};
        set_frame(zr, zi, none, 1'b0);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", int'(bus.in_ready), 1);
        check("rst_mag_valid", int'(bus.mag_valid), 0);
        check("rst_mag_out", int'(bus.mag_out), 0);
        check("rst_mag_idx", int'(bus.mag_idx), 0);
        check("rst_mag_last", int'(bus.mag_last), 0);
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed frames with hand-computed magnitudes
        set_frame(t1r, t1i, t1l, 1'b1);
        send_frame();
        wait_drain();
        set_frame(t2r, t2r, t2l, 1'b1);
        send_frame();
        wait_drain();
        set_frame(t3r, t3i, t3l, 1'b1);
        send_frame();
        wait_drain();

        // Downstream stall on bin 3
        set_random_frame();
        send_frame();
        wait_bin(2);
        ready_mode = 1;
        wait_bin(3);
        repeat (20) @(posedge clk);
        ready_mode = 0;
        wait_drain();

        // Asynchronous reset while bin 5 is in the root engine
        set_random_frame();
        send_frame();
        wait_bin(4);
        @(posedge clk);
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midreset_mag_valid", int'(bus.mag_valid), 0);
        check("midreset_in_ready", int'(bus.in_ready), 1);
        check("midreset_mag_out", int'(bus.mag_out), 0);
        q.delete();
        seen = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        set_frame(t1r, t1i, t1l, 1'b1);
        send_frame();
        wait_drain();

        // in_valid toggling while busy, then a frame chained right after bin 7
        set_random_frame();
        send_frame();
        begin
            int n = 0;
            bit saw7 = 1'b0;
            while (!saw7 && n < 400) begin
                tvalid = 1'($urandom_range(0, 1));
                for (int k = 0; k < NBINS; k++) tyr[k] = DW'($urandom_range(0, 4095));
                @(negedge clk);
                saw7 = bus.mag_valid && (bus.mag_idx == 3'd7);
                @(posedge clk);
                #1;
                n++;
            end
            check("toggle_reached_bin7", int'(saw7), 1);
        end
        set_frame(t3r, t3i, t3l, 1'b1);
        chain_check = 1'b1;
        send_frame();
        wait_drain();

        // Randomised frames under random backpressure
        ready_mode = 2;
        for (int f = 0; f < 6; f++) begin
            set_random_frame();
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            send_frame();
        end
        wait_drain();
        ready_mode = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
